// File: rtl/lemming_dig_if.sv
// Lemming bundle: per-lemming terrain and dig requests in, state decodes and
// shovel arbitration status out.
interface lemming_dig_if #(parameter int N = 4);
    logic [N-1:0] ground;
    logic [N-1:0] bump_left;
    logic [N-1:0] bump_right;
    logic [N-1:0] dig_req;
    logic [N-1:0] walk_left;
    logic [N-1:0] walk_right;
    logic [N-1:0] aaah;
    logic [N-1:0] digging;
    logic [N-1:0] splat;
    logic         shovel_busy;
    logic [1:0]   grant_id;

    modport master (
        output ground, bump_left, bump_right, dig_req,
        input  walk_left, walk_right, aaah, digging, splat, shovel_busy, grant_id
    );

    modport slave (
        input  ground, bump_left, bump_right, dig_req,
        output walk_left, walk_right, aaah, digging, splat, shovel_busy, grant_id
    );
endinterface

// File: rtl/lemming_dig_arbiter.sv
// Four lemming Moore FSMs sharing one shovel; a round-robin arbiter hands the
// shovel to one walking, grounded, requesting lemming whenever nobody digs.

module lemming_dig_lane #(
    parameter int SPLAT_LIMIT = 20
) (
    input  logic clk,
    input  logic areset,
    input  logic ground,
    input  logic bump_left,
    input  logic bump_right,
    input  logic grant,
    output logic walk_left,
    output logic walk_right,
    output logic aaah,
    output logic digging,
    output logic splat
);
    typedef enum logic [2:0] {WL, WR, FALLL, FALLR, DIGL, DIGR, SPLAT} state_t;

    localparam logic [4:0] LIMIT = 5'(SPLAT_LIMIT);

    state_t     state, state_nxt;
    logic [4:0] fall_cnt, fall_cnt_nxt;
    logic       falling, falling_nxt;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state    <= WL;
            fall_cnt <= '0;
        end else begin
            state    <= state_nxt;
            fall_cnt <= fall_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WL: begin
                if (!ground)        state_nxt = FALLL;
                else if (grant)     state_nxt = DIGL;
                else if (bump_left) state_nxt = WR;
            end
            WR: begin
                if (!ground)         state_nxt = FALLR;
                else if (grant)      state_nxt = DIGR;
                else if (bump_right) state_nxt = WL;
            end
            FALLL: if (ground) state_nxt = (fall_cnt >= LIMIT) ? SPLAT : WL;
            FALLR: if (ground) state_nxt = (fall_cnt >= LIMIT) ? SPLAT : WR;
            DIGL:  if (!ground) state_nxt = FALLL;
            DIGR:  if (!ground) state_nxt = FALLR;
            SPLAT: state_nxt = SPLAT;
            default: state_nxt = WL;
        endcase
    end

    // Counter is zero in every non-fall state, so the value on the landing
    // cycle equals the number of edges already spent falling.
    assign falling     = (state == FALLL) || (state == FALLR);
    assign falling_nxt = (state_nxt == FALLL) || (state_nxt == FALLR);

    always_comb begin
        fall_cnt_nxt = '0;
        if (falling_nxt && falling)
            fall_cnt_nxt = (fall_cnt == 5'd31) ? fall_cnt : fall_cnt + 5'd1;
    end

    assign walk_left  = (state == WL);
    assign walk_right = (state == WR);
    assign aaah       = falling;
    assign digging    = (state == DIGL) || (state == DIGR);
    assign splat      = (state == SPLAT);
endmodule

module lemming_dig_arbiter #(
    parameter int N           = 4,
    parameter int SPLAT_LIMIT = 20
) (
    input  logic          clk,
    input  logic          areset,
    lemming_dig_if.slave  dig
);
    logic [N-1:0] walk_left, walk_right, aaah, digging, splat;
    logic [N-1:0] eligible, grant;
    logic [1:0]   grant_id_q, grant_idx, idx;
    logic         shovel_busy, found;

    lemming_dig_lane #(.SPLAT_LIMIT(SPLAT_LIMIT)) u_lane [N-1:0] (
        .clk        (clk),
        .areset     (areset),
        .ground     (dig.ground),
        .bump_left  (dig.bump_left),
        .bump_right (dig.bump_right),
        .grant      (grant),
        .walk_left  (walk_left),
        .walk_right (walk_right),
        .aaah       (aaah),
        .digging    (digging),
        .splat      (splat)
    );

    assign shovel_busy = |digging;
    assign eligible    = (walk_left | walk_right) & dig.ground & dig.dig_req;

    // Search starts just after the last winner and wraps; k=N revisits it last.
    always_comb begin
        grant     = '0;
        grant_idx = grant_id_q;
        found     = 1'b0;
        idx       = '0;
        if (!shovel_busy) begin
            for (int k = 1; k <= N; k++) begin
                idx = grant_id_q + 2'(k);
                if (!found && eligible[idx]) begin
                    found     = 1'b1;
                    grant_idx = idx;
                end
            end
        end
        if (found) grant[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset)     grant_id_q <= 2'd3;
        else if (found) grant_id_q <= grant_idx;
    end

    assign dig.walk_left   = walk_left;
    assign dig.walk_right  = walk_right;
    assign dig.aaah        = aaah;
    assign dig.digging     = digging;
    assign dig.splat       = splat;
    assign dig.shovel_busy = shovel_busy;
    assign dig.grant_id    = grant_id_q;
endmodule

// File: tb/tb_lemming_dig_arbiter.sv
// Directed vectors plus hand sequences for falls, splat, fairness and async reset.
module tb_lemming_dig_arbiter;
    logic clk = 1'b0;
    logic areset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    lemming_dig_if #(.N(4)) dig ();

    lemming_dig_arbiter #(.N(4), .SPLAT_LIMIT(20)) dut (
        .clk    (clk),
        .areset (areset),
        .dig    (dig)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] g, bl, br, req;
        logic [3:0] wl, wr, aa, dg, sp;
        logic       busy;
        logic [1:0] gid;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] wl, input logic [3:0] wr,
                           input logic [3:0] aa, input logic [3:0] dg, input logic [3:0] sp,
                           input logic busy, input logic [1:0] gid);
        chk({tag, ".walk_left"},   dig.walk_left,  wl);
        chk({tag, ".walk_right"},  dig.walk_right, wr);
        chk({tag, ".aaah"},        dig.aaah,       aa);
        chk({tag, ".digging"},     dig.digging,    dg);
        chk({tag, ".splat"},       dig.splat,      sp);
        chk({tag, ".shovel_busy"}, {3'b000, dig.shovel_busy}, {3'b000, busy});
        chk({tag, ".grant_id"},    {2'b00, dig.grant_id},     {2'b00, gid});
    endtask

    task automatic drive(input logic [3:0] g, input logic [3:0] bl, input logic [3:0] br,
                         input logic [3:0] req);
        dig.ground     = g;
        dig.bump_left  = bl;
        dig.bump_right = br;
        dig.dig_req    = req;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 areset = 1'b1;
        #2 areset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        //          g        bl       br       req      wl       wr       aa       dg       sp      busy gid
        tbl[0]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0110, 4'b1101, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b1, 2'd1};
        tbl[1]  = '{4'b1101, 4'b0000, 4'b0000, 4'b0110, 4'b1101, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 1'b0, 2'd1};
        tbl[2]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0110, 4'b1011, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b1, 2'd2};
        tbl[3]  = '{4'b1111, 4'b1000, 4'b0000, 4'b1000, 4'b0011, 4'b1000, 4'b0000, 4'b0100, 4'b0000, 1'b1, 2'd2};
        tbl[4]  = '{4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 4'b1000, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd2};
        tbl[5]  = '{4'b1111, 4'b0000, 4'b1000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd2};
        tbl[6]  = '{4'b1111, 4'b1000, 4'b0000, 4'b1001, 4'b0111, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 1'b1, 2'd3};
        tbl[7]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0111, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 1'b1, 2'd3};
        tbl[8]  = '{4'b0111, 4'b0000, 4'b0000, 4'b0001, 4'b0111, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 1'b0, 2'd3};
        tbl[9]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b1110, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b1, 2'd0};
        tbl[10] = '{4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b1110, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0};
        tbl[11] = '{4'b1111, 4'b0001, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};
        tbl[12] = '{4'b1111, 4'b0001, 4'b0000, 4'b0000, 4'b1110, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};

        drive(4'b1111, 4'b0000, 4'b0000, 4'b0000);
        #23;
        chk_all("reset_held", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd3);
        areset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].g, tbl[i].bl, tbl[i].br, tbl[i].req);
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].wl, tbl[i].wr, tbl[i].aa, tbl[i].dg,
                    tbl[i].sp, tbl[i].busy, tbl[i].gid);
        end

        // Fall of 20 edges lands; 21 edges splats and the splat is sticky.
        do_reset();
        drive(4'b1111, 4'b0001, 4'b0000, 4'b0000);
        step();
        drive(4'b1110, 4'b0000, 4'b0000, 4'b0000);
        repeat (20) step();
        chk_all("fall20_air", 4'b1110, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd3);
        drive(4'b1111, 4'b0000, 4'b0000, 4'b0000);
        step();
        chk_all("fall20_land", 4'b1110, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd3);
        drive(4'b1110, 4'b0000, 4'b0000, 4'b0000);
        repeat (21) step();
        drive(4'b1111, 4'b0000, 4'b0000, 4'b0000);
        step();
        chk_all("fall21_splat", 4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd3);
        drive(4'b1111, 4'b0001, 4'b0001, 4'b0001);
        repeat (3) step();
        chk_all("splat_sticky", 4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd3);

        // Everyone requests; one-cycle ground drops release the shovel in turn.
        do_reset();
        drive(4'b1111, 4'b0000, 4'b0000, 4'b1111);
        step();
        chk("rr_grant0", {2'b00, dig.grant_id}, 4'd0);
        chk("rr_dig0", dig.digging, 4'b0001);
        for (int k = 1; k <= 4; k++) begin
            automatic logic [1:0] prev = 2'(k - 1);
            automatic logic [1:0] nxt  = 2'(k);
            automatic logic [3:0] gnd  = 4'b1111;
            gnd[prev] = 1'b0;
            drive(gnd, 4'b0000, 4'b0000, 4'b1111);
            step();
            chk($sformatf("rr_gap%0d_busy", k), {3'b000, dig.shovel_busy}, 4'd0);
            drive(4'b1111, 4'b0000, 4'b0000, 4'b1111);
            step();
            chk($sformatf("rr_grant%0d", k), {2'b00, dig.grant_id}, {2'b00, nxt});
            chk($sformatf("rr_dig%0d", k), dig.digging, 4'b0001 << nxt);
        end

        // Async reset mid-dig and mid-fall, then a clean 20-edge fall.
        do_reset();
        drive(4'b1111, 4'b0000, 4'b0000, 4'b0100);
        step();
        chk("pre_dig2", dig.digging, 4'b0100);
        drive(4'b1110, 4'b0000, 4'b0000, 4'b0100);
        repeat (4) step();
        chk("pre_fall0", dig.aaah, 4'b0001);
        #2 areset = 1'b1;
        #1;
        chk_all("async_reset", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd3);
        #1 areset = 1'b0;
        drive(4'b1110, 4'b0000, 4'b0000, 4'b0000);
        #1;
        chk("post_reset_dig", dig.digging, 4'b0000);
        repeat (20) step();
        drive(4'b1111, 4'b0000, 4'b0000, 4'b0000);
        step();
        chk_all("post_reset_fall20", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lemming_dig_arbiter.md
LEMMING_DIG_ARBITER -- requirements
Module: lemming_dig_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of lemmings; it is fixed at 4 in this revision.
REQ-002 SHALL have parameter SPLAT_LIMIT, default 20, meaning the fall-counter threshold for splat.
REQ-003 SHALL have input clk, 1 bit: clock, rising-edge.
REQ-004 SHALL have input areset, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have input ground, N bits: per-lemming ground present.
REQ-006 SHALL have input bump_left, N bits: per-lemming left obstacle.
REQ-007 SHALL have input bump_right, N bits: per-lemming right obstacle.
REQ-008 SHALL have input dig_req, N bits: per-lemming request for the single shared shovel.
REQ-009 SHALL have outputs walk_left, walk_right, aaah, digging and splat, each N bits, each a one-hot-per-lemming state decode.
REQ-010 SHALL have output shovel_busy, 1 bit: some lemming is in a dig state.
REQ-011 SHALL have output grant_id, 2 bits: index of the last lemming granted the shovel.

Function
REQ-012 SHALL keep one Moore FSM per lemming with states WL, WR, FALLL, FALLR, DIGL, DIGR, SPLAT.
REQ-013 SHALL decode each output bit i purely from state[i], as follows.
- walk_left = WL; walk_right = WR.
- aaah = FALLL or FALLR; digging = DIGL or DIGR; splat = SPLAT.
REQ-014 SHALL apply these transitions from WL/WR, highest priority first.
- !ground goes to FALLL/FALLR respectively.
- A shovel grant to this lemming goes to DIGL/DIGR.
- bump_left in WL goes to WR; bump_right in WR goes to WL.
- Otherwise the lemming holds its state.
REQ-015 SHALL, in WL/WR, ignore the bump whenever a dig grant is taken, and ignore dig_req without a grant.
REQ-016 SHALL hold DIGL/DIGR while ground=1, and go to FALLL/FALLR when ground=0.
REQ-017 SHALL give each lemming a 5-bit fall counter.
- Counter is cleared to 0 in any state other than FALLL/FALLR.
- Counter increments by 1 on every clock in FALLL/FALLR, saturating at 31.
REQ-018 SHALL, in FALLL/FALLR with ground=1, go to SPLAT when the counter is >= SPLAT_LIMIT, else to WL/WR respectively.
- Net effect: occupying a fall state for 21 or more cycles splats.
REQ-019 SHALL make SPLAT absorbing; only areset exits it.
REQ-020 SHALL compute shovel_busy as the OR of digging, from registered state.
REQ-021 SHALL define eligible[i] = state[i] in {WL,WR} AND ground[i] AND dig_req[i].
REQ-022 SHALL grant at most one lemming per cycle, only when shovel_busy=0.
REQ-023 SHALL choose the grant round-robin among eligible lemmings, searching from grant_id+1 modulo 4 upward.
REQ-024 SHALL update grant_id to the granted index at the same edge the winner enters DIG, and hold it otherwise.
REQ-025 SHALL NOT grant in the cycle the digger leaves DIG, because shovel_busy is still 1 that cycle; the earliest new grant is the following cycle.
REQ-026 SHALL never have two lemmings in DIGL/DIGR simultaneously.

Reset
REQ-027 SHALL, on areset, asynchronously set every lemming to WL, every fall counter to 0 and grant_id to 3.
- Resulting outputs: walk_left=4'b1111; walk_right, aaah, digging, splat = 0; shovel_busy=0.
- With grant_id=3, the first arbitration search starts at lemming 0.
REQ-028 SHALL make areset asserted mid-dig or mid-fall abort the operation immediately, with no pending grant surviving.

Verification
REQ-029 Reset then ground=1111, dig_req=0110 -> next edge: digging=0010, grant_id=1, shovel_busy=1; lemming 2 stays walk_left.
REQ-030 Continue with REQ-029 and drop ground[1] for one cycle -> lemming 1 aaah=1; the grant to lemming 2 occurs one cycle after the FALLL edge, not the same cycle; grant_id=2.
REQ-031 Lemming 0 in WR with ground=0 for 20 cycles then ground=1 -> walk_right; with ground=0 for 21 cycles then ground=1 -> splat[0]=1, and it stays splat through bumps and dig_req.
REQ-032 Lemming 3 in WL with bump_left=1, dig_req=1, shovel free -> DIGL with no direction change; the same stimulus with shovel busy -> WR.
REQ-033 All four lemmings request continuously, each grant released by a one-cycle ground drop -> grant order 0,1,2,3,0 with no starvation.
REQ-034 areset pulsed while lemming 2 digs and lemming 0 falls -> all outputs return to reset values immediately without waiting for clk; after release, a fresh fall of 20 cycles lands without splat.
